// File: rtl/sample_mem_packer.sv
// sample_mem_packer: packs a byte-wide sample stream into 64-bit words and
// writes them through the second port of the shared on-chip memory.
// One capture per start pulse; done pulses after the last (possibly partial)
// word has been written.
module sample_mem_packer #(
    parameter logic [13:0] BASE_ADDR = 14'd0,
    parameter int          MAX_BYTES = 131072
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [17:0] num_bytes,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [13:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    output logic [7:0]  mem_byteenable,
    output logic        busy,
    output logic        done,
    output logic [14:0] words_written
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [17:0] MAX_B = 18'(MAX_BYTES);

    logic [1:0]  state_q, state_d;
    logic [17:0] rem_q, rem_d;
    logic [2:0]  lane_q, lane_d;
    logic [13:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [14:0] ww_q, ww_d;
    // Memory-port copies: loaded only when a word is handed to WRITE so the
    // bus holds its last written value between writes.
    logic [13:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_be_q, mem_be_d;
    logic        clken_q;

    logic        hs;

    assign hs = in_valid && (state_q == S_FILL);

    // Next-state logic for the capture FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ww_d        = ww_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_bytes == 18'd0) begin
                        state_d = S_DONE;
                    end else begin
                        rem_d   = (num_bytes > MAX_B) ? MAX_B : num_bytes;
                        lane_d  = 3'd0;
                        addr_d  = BASE_ADDR;
                        wdata_d = 64'd0;
                        be_d    = 8'd0;
                        ww_d    = 15'd0;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (hs) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = in_data;
                    be_d[lane_q] = 1'b1;
                    rem_d  = rem_q - 18'd1;
                    lane_d = lane_q + 3'd1;
                    if (lane_q == 3'd7 || rem_q == 18'd1) begin
                        state_d     = S_WRITE;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = wdata_d;
                        mem_be_d    = be_d;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 14'd1;
                ww_d    = ww_q + 15'd1;
                lane_d  = 3'd0;
                wdata_d = 64'd0;
                be_d    = 8'd0;
                state_d = (rem_q == 18'd0) ? S_DONE : S_FILL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start; the word
        // count and the memory bus keep their previous values.
        if (abort) begin
            state_d     = S_IDLE;
            ww_d        = ww_q;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
            mem_be_d    = mem_be_q;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rem_q       <= 18'd0;
            lane_q      <= 3'd0;
            addr_q      <= 14'd0;
            wdata_q     <= 64'd0;
            be_q        <= 8'd0;
            ww_q        <= 15'd0;
            mem_addr_q  <= 14'd0;
            mem_wdata_q <= 64'd0;
            mem_be_q    <= 8'd0;
            clken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ww_q        <= ww_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            clken_q     <= 1'b1;
        end
    end

    assign in_ready       = (state_q == S_FILL);
    assign busy           = (state_q == S_FILL) || (state_q == S_WRITE);
    assign done           = (state_q == S_DONE);
    assign mem_write      = (state_q == S_WRITE);
    assign mem_chipselect = (state_q == S_WRITE);
    assign mem_clken      = clken_q;
    assign mem_address    = mem_addr_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_byteenable = mem_be_q;
    assign words_written  = ww_q;

endmodule

// File: tb/tb_sample_mem_packer.sv
// Directed testbench for sample_mem_packer: a default instance plus a
// second instance with a wrapping base address and a small capture limit.
module tb_sample_mem_packer;

    logic        clk;
    logic        reset_n;
    logic        start_a, start_b;
    logic [17:0] num_bytes;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy_a, cs_a, ck_a, wr_a, busy_a, done_a;
    logic [13:0] addr_a;
    logic [63:0] wd_a;
    logic [7:0]  be_a;
    logic [14:0] ww_a;

    logic        rdy_b, cs_b, ck_b, wr_b, busy_b, done_b;
    logic [13:0] addr_b;
    logic [63:0] wd_b;
    logic [7:0]  be_b;
    logic [14:0] ww_b;

    logic        sel_b;
    logic        cur_rdy, cur_cs, cur_ck, cur_wr, cur_busy, cur_done;
    logic [13:0] cur_addr;
    logic [63:0] cur_wd;
    logic [7:0]  cur_be;
    logic [14:0] cur_ww;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_in_wr = 0;
    int cs_bad = 0;

    logic [13:0] wq_addr[$];
    logic [63:0] wq_data[$];
    logic [7:0]  wq_be[$];
    int          wq_cyc[$];
    int          dq_cyc[$];

    sample_mem_packer u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .num_bytes(num_bytes),
        .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
        .mem_address(addr_a), .mem_chipselect(cs_a), .mem_clken(ck_a),
        .mem_write(wr_a), .mem_writedata(wd_a), .mem_byteenable(be_a),
        .busy(busy_a), .done(done_a), .words_written(ww_a)
    );

    sample_mem_packer #(.BASE_ADDR(14'd16383), .MAX_BYTES(16)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .num_bytes(num_bytes),
        .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
        .mem_address(addr_b), .mem_chipselect(cs_b), .mem_clken(ck_b),
        .mem_write(wr_b), .mem_writedata(wd_b), .mem_byteenable(be_b),
        .busy(busy_b), .done(done_b), .words_written(ww_b)
    );

    assign cur_rdy  = sel_b ? rdy_b  : rdy_a;
    assign cur_cs   = sel_b ? cs_b   : cs_a;
    assign cur_ck   = sel_b ? ck_b   : ck_a;
    assign cur_wr   = sel_b ? wr_b   : wr_a;
    assign cur_busy = sel_b ? busy_b : busy_a;
    assign cur_done = sel_b ? done_b : done_a;
    assign cur_addr = sel_b ? addr_b : addr_a;
    assign cur_wd   = sel_b ? wd_b   : wd_a;
    assign cur_be   = sel_b ? be_b   : be_a;
    assign cur_ww   = sel_b ? ww_b   : ww_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and done log of the selected instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (cur_wr) begin
                wq_addr.push_back(cur_addr);
                wq_data.push_back(cur_wd);
                wq_be.push_back(cur_be);
                wq_cyc.push_back(cyc);
                if (cur_rdy) rdy_in_wr = rdy_in_wr + 1;
                if (!cur_cs) cs_bad = cs_bad + 1;
            end
            if (cur_done) dq_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [13:0] ea,
                             input logic [63:0] ed, input logic [7:0] eb);
        if (idx < wq_addr.size()) begin
            chk({tag, "_addr"}, 64'(wq_addr[idx]), 64'(ea));
            chk({tag, "_data"}, wq_data[idx], ed);
            chk({tag, "_be"}, 64'(wq_be[idx]), 64'(eb));
        end else begin
            chk({tag, "_present"}, 64'd0, 64'd1);
        end
    endtask

    // Little-endian word built from consecutive bytes first, first+1, ...
    function automatic logic [63:0] word_of(input int first, input int nb);
        logic [63:0] w;
        w = 64'd0;
        for (int k = 0; k < nb; k++) w[8*k +: 8] = 8'(first + k);
        return w;
    endfunction

    task automatic do_start(input logic b, input logic [17:0] n, output int s);
        sel_b = b;
        @(posedge clk); #1;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        num_bytes = n;
        s = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offers bytes 1,2,3,... and advances only on an actual handshake.
    task automatic drive_bytes(input int n, input bit gaps, input int budget, output int taken);
        int c;
        bit take;
        taken = 0;
        c = 0;
        while (taken < n && c < budget) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = 8'(taken + 1);
            @(negedge clk);
            take = in_valid && cur_rdy;
            @(posedge clk); #1;
            if (take) taken = taken + 1;
            c = c + 1;
        end
        in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s, t, wb, db, rb;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; num_bytes = 18'd0;
        abort = 1'b0; in_valid = 1'b0; in_data = 8'd0; sel_b = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(cur_rdy), 64'd0);
        chk("rst_busy", 64'(cur_busy), 64'd0);
        chk("rst_done", 64'(cur_done), 64'd0);
        chk("rst_write", 64'(cur_wr), 64'd0);
        chk("rst_clken", 64'(cur_ck), 64'd0);
        chk("rst_ww", 64'(cur_ww), 64'd0);
        chk("rst_bus", {cur_wd[47:0], cur_addr, 2'b00}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle(1);
        chk("clken_after_reset", 64'(cur_ck), 64'd1);

        // Full word, continuous input
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b0, 18'd8, s);
        chk("full_ready_c1", 64'(cur_rdy), 64'd1);
        drive_bytes(8, 1'b0, 50, t);
        chk("full_taken", 64'(t), 64'd8);
        settle(4);
        chk("full_nwrites", 64'(wq_addr.size() - wb), 64'd1);
        chk_write("full_w0", wb, 14'd0, 64'h0807060504030201, 8'hFF);
        if (wb < wq_cyc.size()) chk("full_wcycle", 64'(wq_cyc[wb] - s), 64'd9);
        else chk("full_wcycle_present", 64'd0, 64'd1);
        chk("full_ndone", 64'(dq_cyc.size() - db), 64'd1);
        if (db < dq_cyc.size()) chk("full_dcycle", 64'(dq_cyc[db] - s), 64'd10);
        else chk("full_dcycle_present", 64'd0, 64'd1);
        chk("full_ww", 64'(cur_ww), 64'd1);

        // Partial final word
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b0, 18'd11, s);
        drive_bytes(11, 1'b0, 50, t);
        settle(4);
        chk("part_nwrites", 64'(wq_addr.size() - wb), 64'd2);
        chk_write("part_w0", wb, 14'd0, 64'h0807060504030201, 8'hFF);
        chk_write("part_w1", wb + 1, 14'd1, 64'h00000000000B0A09, 8'h07);
        chk("part_ndone", 64'(dq_cyc.size() - db), 64'd1);
        chk("part_ww", 64'(cur_ww), 64'd2);

        // Gapped input, 40 bytes
        wb = wq_addr.size(); db = dq_cyc.size(); rb = rdy_in_wr;
        do_start(1'b0, 18'd40, s);
        drive_bytes(40, 1'b1, 400, t);
        chk("gap_taken", 64'(t), 64'd40);
        settle(4);
        chk("gap_nwrites", 64'(wq_addr.size() - wb), 64'd5);
        for (int w = 0; w < 5; w++)
            chk_write($sformatf("gap_w%0d", w), wb + w, 14'(w), word_of(8*w + 1, 8), 8'hFF);
        chk("gap_ready_in_write", 64'(rdy_in_wr - rb), 64'd0);
        chk("gap_cs_in_write", 64'(cs_bad), 64'd0);
        chk("gap_ndone", 64'(dq_cyc.size() - db), 64'd1);
        chk("gap_ww", 64'(cur_ww), 64'd5);
        chk("gap_addr_hold", 64'(cur_addr), 64'd4);
        chk("gap_data_hold", cur_wd, word_of(33, 8));

        // Empty capture
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b0, 18'd0, s);
        settle(3);
        chk("empty_nwrites", 64'(wq_addr.size() - wb), 64'd0);
        chk("empty_ndone", 64'(dq_cyc.size() - db), 64'd1);
        if (db < dq_cyc.size()) chk("empty_dcycle", 64'(dq_cyc[db] - s), 64'd1);
        else chk("empty_dcycle_present", 64'd0, 64'd1);

        // Abort after 3 bytes, then a clean restart
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b0, 18'd10, s);
        drive_bytes(3, 1'b0, 20, t);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(cur_rdy), 64'd0);
        chk("abort_busy", 64'(cur_busy), 64'd0);
        settle(4);
        chk("abort_nwrites", 64'(wq_addr.size() - wb), 64'd0);
        chk("abort_ndone", 64'(dq_cyc.size() - db), 64'd0);
        chk("abort_ww", 64'(cur_ww), 64'd0);
        do_start(1'b0, 18'd8, s);
        drive_bytes(8, 1'b0, 50, t);
        settle(4);
        chk("restart_nwrites", 64'(wq_addr.size() - wb), 64'd1);
        chk_write("restart_w0", wb, 14'd0, 64'h0807060504030201, 8'hFF);
        chk("restart_ndone", 64'(dq_cyc.size() - db), 64'd1);

        // Asynchronous reset in the middle of FILL
        do_start(1'b0, 18'd16, s);
        drive_bytes(2, 1'b0, 20, t);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", 64'(cur_rdy), 64'd0);
        chk("arst_busy", 64'(cur_busy), 64'd0);
        chk("arst_data", cur_wd, 64'd0);
        chk("arst_clken", 64'(cur_ck), 64'd0);
        chk("arst_ww", 64'(cur_ww), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle(1);

        // Address wrap on the second instance
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b1, 18'd16, s);
        drive_bytes(16, 1'b0, 60, t);
        settle(4);
        chk("wrap_nwrites", 64'(wq_addr.size() - wb), 64'd2);
        chk_write("wrap_w0", wb, 14'd16383, word_of(1, 8), 8'hFF);
        chk_write("wrap_w1", wb + 1, 14'd0, word_of(9, 8), 8'hFF);
        chk("wrap_ndone", 64'(dq_cyc.size() - db), 64'd1);

        // Oversized count clamps to the capture limit
        wb = wq_addr.size(); db = dq_cyc.size();
        do_start(1'b1, 18'd200000, s);
        drive_bytes(20, 1'b0, 40, t);
        settle(4);
        chk("clamp_taken", 64'(t), 64'd16);
        chk("clamp_nwrites", 64'(wq_addr.size() - wb), 64'd2);
        chk_write("clamp_w1", wb + 1, 14'd0, word_of(9, 8), 8'hFF);
        chk("clamp_ndone", 64'(dq_cyc.size() - db), 64'd1);
        chk("clamp_ww", 64'(cur_ww), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_mem_packer.md
# sample_mem_packer

Packs the byte-wide sample stream from the SERDES channel model into 64-bit words. Writes those words into the NIOS_UART system's shared on-chip memory through its second port (`on_chip_mem_s2_*`), where NIOS firmware reads them and sends them out over the UART. One capture is armed by `start` with a byte count. `done` pulses when the last, possibly partial, word has been written.

## Interface

Parameters:
- `BASE_ADDR`, default 0: word address of the first write (14-bit).
- `MAX_BYTES`, default 131072: capture limit, equal to 16384 words × 8 bytes. A larger `num_bytes` is clamped to this value.

Ports:
- `clk` in 1: system clock, the same clock as `clk_clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle arm pulse. Ignored unless the block is in IDLE.
- `num_bytes` in 18: byte count, latched when `start` is accepted.
- `abort` in 1: synchronous cancel of the current capture.
- `in_valid` in 1: the sample byte on `in_data` is valid.
- `in_data` in 8: sample byte.
- `in_ready` out 1: the block accepts a byte in any cycle where `in_valid` and `in_ready` are both high.
- `mem_address` out 14: connects to `on_chip_mem_s2_address`.
- `mem_chipselect` out 1: connects to `on_chip_mem_s2_chipselect`.
- `mem_clken` out 1: connects to `on_chip_mem_s2_clken`.
- `mem_write` out 1: connects to `on_chip_mem_s2_write`.
- `mem_writedata` out 64: connects to `on_chip_mem_s2_writedata`.
- `mem_byteenable` out 8: connects to `on_chip_mem_s2_byteenable`.
- `busy` out 1: a capture is in progress.
- `done` out 1: one-cycle completion pulse.
- `words_written` out 15: number of words written in the current or last capture.

## Operation

FSM states are IDLE, FILL, WRITE and DONE.

- **IDLE**
  - `in_ready`, `busy` and `mem_write` are 0.
  - On `start` with `num_bytes` = 0: go to DONE and write nothing.
  - On `start` with `num_bytes` ≠ 0:
    - latch `rem` = min(`num_bytes`, `MAX_BYTES`);
    - set `lane` = 0, `addr` = `BASE_ADDR`, `wdata` = 0, `be` = 0;
    - clear `words_written`;
    - go to FILL.
- **FILL**
  - `in_ready` = 1 and `busy` = 1.
  - On each handshake:
    - the byte goes to `wdata[8*lane+7 : 8*lane]`;
    - set `be[lane]`;
    - decrement `rem` and increment `lane`.
  - If `lane` was 7, or `rem` was 1, go to WRITE.
- **WRITE**
  - Lasts exactly one cycle, with `in_ready` = 0.
  - `mem_chipselect` = 1 and `mem_write` = 1.
  - `mem_address` = `addr`, `mem_writedata` = `wdata`, `mem_byteenable` = `be`.
  - Next cycle:
    - `addr` += 1, wrapping modulo 2^14;
    - `words_written` += 1;
    - `lane`, `wdata` and `be` are cleared;
    - go to DONE if `rem` = 0, otherwise to FILL.
- **DONE**: `done` = 1 and `busy` = 0 for one cycle, then go to IDLE.

Boundary rules:
- Unused lanes of a partial final word carry `wdata` = 0 and `be` = 0.
- `mem_clken` is 1 in every cycle after reset.
- Outside WRITE, `mem_chipselect` = 0 and `mem_write` = 0. `mem_address`, `mem_writedata` and `mem_byteenable` hold their last values.
- `abort` in any state goes to IDLE on the next cycle:
  - no `done` pulse;
  - a WRITE in progress in the abort cycle still completes;
  - `words_written` holds its value.
- `abort` takes priority over `start` in the same cycle.
- `start` during FILL, WRITE or DONE is ignored.
- `in_valid` while `in_ready` = 0 is not consumed. The source must hold the byte.

## Timing

- Reset values: every output and register is 0 (`state` = IDLE, `mem_clken` = 0, `in_ready` = 0, `words_written` = 0).
- `start` accepted at cycle 0 puts the block in FILL at cycle 1, with `in_ready` high at cycle 1.
- With continuous `in_valid`, bytes are accepted in cycles 1–8 and the WRITE happens at cycle 9. Throughput is 8 bytes per 9 cycles.
- After the final WRITE at cycle N, `done` is high at cycle N+1 and `in_ready` is low from cycle N onward.
- `start` with `num_bytes` = 0 at cycle 0 gives `done` at cycle 1.
- `busy` is high from cycle 1 through the last WRITE cycle.
- Memory write latency: the write is committed at the clock edge ending the WRITE cycle. No readback is performed.

## Test plan

- **Full word, continuous input.** `num_bytes` = 8 with bytes 0x01..0x08 →
  - one write: `mem_address` = 0, `mem_writedata` = 0x0807060504030201, `mem_byteenable` = 0xFF, at cycle 9;
  - `done` at cycle 10;
  - `words_written` = 1.
- **Partial final word.** `num_bytes` = 11 with bytes 0x01..0x0B →
  - write at address 0: data 0x0807060504030201, byteenable 0xFF;
  - write at address 1: data 0x00000000000B0A09, byteenable 0x07;
  - `done` pulses once; `words_written` = 2.
- **Gapped input.** Random gaps in `in_valid` with `num_bytes` = 40 →
  - 5 writes whose data equals the input byte sequence;
  - `in_ready` = 0 in every WRITE cycle;
  - no byte dropped or duplicated.
- **Empty and oversized counts.**
  - `num_bytes` = 0 → `done` at cycle 1 and no `mem_write`.
  - `num_bytes` = 200000 → capture stops after 16384 writes and 131072 bytes.
- **Address wrap.** `BASE_ADDR` = 16383, `num_bytes` = 16 → writes at address 16383 and then address 0.
- **Abort and reset mid-capture.**
  - `abort` after 3 accepted bytes → no write, no `done`, `in_ready` = 0 on the next cycle, and a new `start` then works normally.
  - `reset_n` low mid-FILL → all outputs 0 asynchronously, without waiting for a clock edge.
